// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative HI/LO multiply/divide unit, one bit per cycle.
// Optional MULDIV_EARLY_TERM_EN ends multiplies once the multiplier is exhausted.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier, r_hi, r_lo;
    logic               r_busy, r_done, r_div, r_neg_q, r_neg_r;
    logic               w_sgn, w_md, w_last;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_mplier_nx, w_rem, w_quo;
    logic [WIDTH:0]     w_rem_sh, w_diff;
    logic [2*WIDTH-1:0] w_acc_nx, w_mcand_nx, w_prod;
    assign w_sgn   = op_code[0];
    assign w_md    = ~op_code[2];
    assign w_abs_a = (w_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_abs_b = (w_sgn && op_b[WIDTH-1]) ? -op_b : op_b;
    // Divide reuses the datapath: remainder in r_acc upper half, dividend/quotient in r_mplier, divisor in r_mcand.
    assign w_rem_sh    = {r_acc[2*WIDTH-1:WIDTH], r_mplier[WIDTH-1]};
    assign w_diff      = w_rem_sh - {1'b0, r_mcand[WIDTH-1:0]};
    assign w_mplier_nx = r_div ? {r_mplier[WIDTH-2:0], ~w_diff[WIDTH]} : r_mplier >> 1;
    assign w_acc_nx    = r_div ? {(w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]), r_acc[WIDTH-1:0]}
                               : r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mcand_nx  = r_div ? r_mcand : r_mcand << 1;
`ifdef MULDIV_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(WIDTH - 1)) || (!r_div && w_mplier_nx == '0);
`else
    assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_quo  = r_neg_q ? -r_mplier : r_mplier;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (op_valid) begin
                    if (w_md) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_div    <= op_code[1];
                        r_mcand  <= {{WIDTH{1'b0}}, op_code[1] ? w_abs_b : w_abs_a};
                        r_mplier <= op_code[1] ? w_abs_a : w_abs_b;
                        r_neg_q  <= w_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        r_neg_r  <= w_sgn & op_a[WIDTH-1];
                    end else if (op_code == 3'b100) r_hi <= op_a;
                    else if (op_code == 3'b101) r_lo <= op_a;
                end
                RUN: begin
                    r_acc    <= w_acc_nx;
                    r_mcand  <= w_mcand_nx;
                    r_mplier <= w_mplier_nx;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) r_state <= FIN;
                end
                FIN: begin
                    {r_hi, r_lo} <= r_div ? {w_rem, w_quo} : w_prod;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- The decode/control stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests through a valid/busy handshake, and the unit computes iteratively (one bit per cycle).
- HI/LO are exported continuously for MFHI/MFLO; the control stage stalls MFHI/MFLO while busy=1.
- This moves HILO ownership off the single-cycle ALU path.

Parameters:
- WIDTH, 32: operand width. HI and LO are WIDTH bits each; the iteration counter is $clog2(WIDTH) bits.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset; one clock; sampled on rising edge of clk only
- op_valid  input  1  request present this cycle
- op_code  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
- op_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
- op_b  input  WIDTH  rt operand (divisor / multiplier)
- busy  output  1  registered; 1 while a mul/div is in flight
- done  output  1  registered one-cycle pulse when a mul/div writes HI/LO
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation with no HI/LO write.
- Accept: a request is accepted at an edge where op_valid=1 and state=IDLE.
  - op_valid while busy=1 is ignored; upstream holds the request.
  - op_code 11x is accepted and has no effect.
- MTHI/MTLO: the accept edge writes op_a to hi or lo. busy stays 0 and done stays 0. Back-to-back accepts are allowed every cycle.
- States and transitions:
  - IDLE -> RUN on accept of a mul/div. At this edge: latch |op_a|, |op_b| (MULT/DIV) or raw operands (MULTU/DIVU), the result sign flags, clear the 2*WIDTH accumulator, set busy=1, counter=0.
  - RUN: one iteration per edge, counter++. At the edge where counter==WIDTH-1 -> FIN.
  - FIN -> IDLE: apply sign correction, write hi/lo, done=1 for exactly one cycle, busy=0.
- Latency: accept edge E0, iterations on E1..E32, FIN on E33. busy=1 for WIDTH+1 cycles. hi/lo/done are valid after E33.
- A new request may be accepted on the edge after done rises (state=IDLE).
- Multiply (shift-add):
  - If multiplier[0]=1, accumulator += multiplicand.
  - Multiplicand (2*WIDTH bits) shifts left 1; multiplier shifts right 1.
  - Result: {hi,lo} = product. MULT negates the 64-bit product when sign(op_a) XOR sign(op_b).
- Divide (restoring): remainder/quotient shift, trial subtract of divisor, quotient bit = no-borrow.
  - Result: lo = quotient, hi = remainder.
  - DIV truncates toward zero. The quotient is negated if signs differ; the remainder takes the sign of op_a.
- Divide by zero (required, not UNPREDICTABLE):
  - DIVU: hi=op_a, lo=all ones.
  - DIV: hi=op_a, lo = op_a[WIDTH-1] ? 1 : all ones.
- DIV overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- All arithmetic uses unsigned magnitudes internally; no $signed * or / operators. Sign handling is by explicit two's-complement negation.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: for MULTU/MULT only, in RUN, if the shifted multiplier value written at this edge is zero, go to FIN instead of continuing. The result is identical to the full run; latency = (index of highest set multiplier-magnitude bit + 1) iterations + FIN.
  - op_b=0: done is valid after E2.
- Undefined: fixed WIDTH+1 cycle latency for all mul/div.
- Divide latency is always fixed.

Test Plan:
- MULTU op_a=0xFFFFFFFF op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses one cycle after E33; busy high 33 cycles (macro undefined).
- MULT op_a=0xFFFFFFFD (-3) op_b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV op_a=0xFFFFFFF9 (-7) op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 10/0 -> hi=0x0000000A, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated the edge after each; busy and done stay 0.
  - Then start DIVU; MTLO 0x1 held during busy -> ignored until done, then accepted.
- Reset_n=0 at cycle 10 of a MULT -> next cycle busy=0, done=0, hi=lo=0. No later done pulse.
- With MULDIV_EARLY_TERM_EN: MULTU 3*2 -> lo=6, hi=0, done after E3. MULTU 7*0 -> lo=0, done after E2. Without the macro, both complete after E33.
